// File: rtl/mips_harvard_mem_model.sv
// ============================================================================
// Module      : mips_harvard_mem_model
// Description : Harvard instruction ROM / data RAM model for CPU benches with
//               init-stream loading, clock-enable generation, address-error
//               flag and saturating write counter. Macro MEM_STALL_EN adds
//               STALL_CYCLES of clk_enable=0 after each accepted data access.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_harvard_mem_model #(
    parameter int          INSTR_DEPTH  = 256,
    parameter int          DATA_DEPTH   = 256,
    parameter logic [31:0] INSTR_BASE   = 32'hBFC00000,
    parameter logic [31:0] DATA_BASE    = 32'h00000000,
    parameter int          STALL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        init_mem,
    input  logic [31:0] init_mem_addr,
    input  logic [31:0] init_instr,
    output logic        clk_enable,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    input  logic [31:0] data_address,
    input  logic        data_write,
    input  logic        data_read,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic        addr_error,
    output logic [15:0] write_count
);

    localparam int IAW = $clog2(INSTR_DEPTH);
    localparam int DAW = $clog2(DATA_DEPTH);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0] instr_mem [0:INSTR_DEPTH-1];
    logic [31:0] data_mem  [0:DATA_DEPTH-1];

    logic [31:0] instr_off;
    logic [31:0] instr_idx;
    logic [31:0] data_off;
    logic [31:0] data_idx;
    logic        instr_valid;
    logic        data_valid;
    logic        data_access;
    logic        access_ok;
    logic        write_ok;
    logic        init_bad;
    logic        err_event;

    // Unsigned wrap below the base yields a huge index, caught by the range check.
    assign instr_off   = instr_address - INSTR_BASE;
    assign instr_idx   = instr_off >> 2;
    assign data_off    = data_address - DATA_BASE;
    assign data_idx    = data_off >> 2;
    assign instr_valid = (instr_address[1:0] == 2'b00) && (instr_idx < 32'(INSTR_DEPTH));
    assign data_valid  = (data_address[1:0] == 2'b00) && (data_idx < 32'(DATA_DEPTH));

    assign instr_readdata = instr_valid ? instr_mem[instr_idx[IAW-1:0]] : 32'd0;
    assign data_readdata  = (data_read && data_valid) ? data_mem[data_idx[DAW-1:0]] : 32'd0;

    assign clk_enable  = !reset && (state == RUN);
    assign data_access = data_read || data_write;
    assign access_ok   = clk_enable && data_access && data_valid;
    assign write_ok    = clk_enable && data_write && data_valid;
    assign init_bad    = init_mem && (init_mem_addr >= 32'(INSTR_DEPTH));
    assign err_event   = init_bad ||
                         (clk_enable && (!instr_valid ||
                                         (data_access && !data_valid) ||
                                         (data_read && data_write)));

`ifdef MEM_STALL_EN
    logic [3:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (reset || init_mem) begin
            stall_cnt <= 4'd0;
        end else if (state == RUN && access_ok) begin
            stall_cnt <= 4'(STALL_CYCLES);
        end else if (state == STALL) begin
            stall_cnt <= stall_cnt - 4'd1;
        end
    end
`else
    if (STALL_CYCLES < 1) begin : g_stall_param_unused
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (init_mem) begin
            state_next = LOAD;
        end else begin
            case (state)
                LOAD:    state_next = RUN;
`ifdef MEM_STALL_EN
                RUN:     state_next = access_ok ? STALL : RUN;
                STALL:   state_next = (stall_cnt <= 4'd1) ? RUN : STALL;
`else
                RUN:     state_next = RUN;
                STALL:   state_next = RUN;
`endif
                default: state_next = RUN;
            endcase
        end
    end

    // Instruction memory deliberately has no reset so programs survive reset.
    always_ff @(posedge clk) begin
        if (!reset && init_mem && !init_bad) begin
            instr_mem[init_mem_addr[IAW-1:0]] <= init_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DATA_DEPTH; i++) begin
                data_mem[i] <= 32'd0;
            end
        end else if (write_ok) begin
            data_mem[data_idx[DAW-1:0]] <= data_writedata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write_count <= 16'd0;
            addr_error  <= 1'b0;
        end else begin
            if (write_ok && write_count != 16'hFFFF) begin
                write_count <= write_count + 16'd1;
            end
            if (err_event) begin
                addr_error <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mips_harvard_mem_model.sv
// Self-checking bench for mips_harvard_mem_model: vector table, corner-case
// sequences and randomized traffic against a behavioural memory model.
`default_nettype none

module tb_mips_harvard_mem_model;

    localparam int          INSTR_DEPTH = 256;
    localparam int          DATA_DEPTH  = 256;
    localparam logic [31:0] INSTR_BASE  = 32'hBFC00000;
    localparam logic [31:0] DATA_BASE   = 32'h00000000;

    logic        clk = 1'b0;
    logic        reset;
    logic        init_mem;
    logic [31:0] init_mem_addr;
    logic [31:0] init_instr;
    logic        clk_enable;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic [31:0] data_address;
    logic        data_write;
    logic        data_read;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;
    logic        addr_error;
    logic [15:0] write_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] prog [0:3];
    logic [31:0] dm   [0:DATA_DEPTH-1];
    int          m_wc;
    bit          m_err;

    typedef struct {
        bit          wr;
        bit          rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [15:0] exp_wc;
        bit          exp_err;
    } vec_t;

    vec_t vecs [0:9];

    mips_harvard_mem_model #(
        .INSTR_DEPTH (INSTR_DEPTH),
        .DATA_DEPTH  (DATA_DEPTH),
        .INSTR_BASE  (INSTR_BASE),
        .DATA_BASE   (DATA_BASE),
        .STALL_CYCLES(2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .init_mem      (init_mem),
        .init_mem_addr (init_mem_addr),
        .init_instr    (init_instr),
        .clk_enable    (clk_enable),
        .instr_address (instr_address),
        .instr_readdata(instr_readdata),
        .data_address  (data_address),
        .data_write    (data_write),
        .data_read     (data_read),
        .data_writedata(data_writedata),
        .data_readdata (data_readdata),
        .addr_error    (addr_error),
        .write_count   (write_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        init_mem       = 1'b0;
        init_mem_addr  = 32'd0;
        init_instr     = 32'd0;
        data_write     = 1'b0;
        data_read      = 1'b0;
        data_address   = 32'd0;
        data_writedata = 32'd0;
        instr_address  = INSTR_BASE;
    endtask

    function automatic bit dvalid(input logic [31:0] a);
        logic [31:0] off;
        off = a - DATA_BASE;
        return (a % 4 == 0) && (off / 4 < DATA_DEPTH);
    endfunction

    task automatic do_reset();
        idle();
        reset = 1'b1;
        #1;
        chk("ce_in_reset", 32'(clk_enable), 32'd0);
        cycle();
        reset = 1'b0;
        #1;
        chk("reset_err", 32'(addr_error), 32'd0);
        chk("reset_wc", 32'(write_count), 32'd0);
        chk("ce_after_reset", 32'(clk_enable), 32'd1);
        for (int i = 0; i < DATA_DEPTH; i++) dm[i] = 32'd0;
        m_wc  = 0;
        m_err = 1'b0;
    endtask

    task automatic data_op(input bit wr, input bit rd, input logic [31:0] addr,
                           input logic [31:0] wdata);
        data_write     = wr;
        data_read      = rd;
        data_address   = addr;
        data_writedata = wdata;
    endtask

    initial begin
        prog[0] = 32'h8C0C0000;
        prog[1] = 32'h8C090000;
        prog[2] = 32'h01891821;
        prog[3] = 32'hAC030000;

        vecs[0] = '{1'b1, 1'b0, 32'h10,  32'd7,      32'd0,      16'd1, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'h10,  32'd0,      32'd7,      16'd1, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 32'h10,  32'd0,      32'd0,      16'd1, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 32'h8,   32'd3,      32'd0,      16'd2, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 32'h8,   32'd0,      32'd3,      16'd2, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 32'h3FC, 32'h000000A5, 32'd0,    16'd3, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 32'h3FC, 32'd0,      32'h000000A5, 16'd3, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 32'h400, 32'd1,      32'd0,      16'd3, 1'b1};
        vecs[8] = '{1'b1, 1'b0, 32'h12,  32'd5,      32'd0,      16'd3, 1'b1};
        vecs[9] = '{1'b0, 1'b1, 32'h10,  32'd0,      32'd7,      16'd3, 1'b1};

        idle();
        reset = 1'b1;
        cycle();
        do_reset();

        // Program load through the init stream
        for (int i = 0; i < 4; i++) begin
            init_mem      = 1'b1;
            init_mem_addr = 32'(i);
            init_instr    = prog[i];
            #1;
            if (i > 0) chk("ce_during_load", 32'(clk_enable), 32'd0);
            cycle();
        end
        init_mem = 1'b0;
        #1;
        chk("ce_first_cycle_after_load", 32'(clk_enable), 32'd0);
        cycle();
        chk("ce_run_after_load", 32'(clk_enable), 32'd1);
        for (int i = 0; i < 4; i++) begin
            instr_address = INSTR_BASE + 32'(4 * i);
            #1;
            chk("instr_read", instr_readdata, prog[i]);
        end
        instr_address = INSTR_BASE;

`ifdef MEM_STALL_EN
        do_reset();
        data_op(1'b1, 1'b0, 32'h10, 32'd7);
        #1;
        chk("stall_ce_wr", 32'(clk_enable), 32'd1);
        cycle();
        data_op(1'b0, 1'b0, 32'h10, 32'd0);
        chk("stall_ce_0a", 32'(clk_enable), 32'd0);
        cycle();
        chk("stall_ce_0b", 32'(clk_enable), 32'd0);
        cycle();
        chk("stall_ce_back", 32'(clk_enable), 32'd1);
        data_op(1'b0, 1'b1, 32'h10, 32'd0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("stall_ce_pattern", 32'(clk_enable), (i == 1 || i == 2) ? 32'd0 : 32'd1);
            chk("stall_rdata", data_readdata, 32'd7);
            cycle();
        end
        chk("stall_wc", 32'(write_count), 32'd1);
        idle();
`else
        // Vector table: write/read, boundary word, bad and misaligned writes
        for (int i = 0; i < 10; i++) begin
            data_op(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata);
            #1;
            chk($sformatf("vec%0d_rdata", i), data_readdata, vecs[i].exp_rdata);
            cycle();
            chk($sformatf("vec%0d_wc", i), 32'(write_count), 32'(vecs[i].exp_wc));
            chk($sformatf("vec%0d_err", i), 32'(addr_error), 32'(vecs[i].exp_err));
        end
        idle();

        // Reset mid-program
        do_reset();
        data_op(1'b1, 1'b0, 32'h0, 32'd5);
        cycle();
        chk("pre_reset_wc", 32'(write_count), 32'd1);
        do_reset();
        data_op(1'b0, 1'b1, 32'h0, 32'd0);
        #1;
        chk("post_reset_dmem0", data_readdata, 32'd0);
        chk("post_reset_imem0", instr_readdata, 32'h8C0C0000);
        idle();

        // Misaligned instruction fetch
        instr_address = 32'hBFC00002;
        #1;
        chk("instr_misaligned_data", instr_readdata, 32'd0);
        cycle();
        instr_address = INSTR_BASE;
        chk("instr_misaligned_err", 32'(addr_error), 32'd1);
        cycle();
        cycle();
        chk("err_sticky", 32'(addr_error), 32'd1);

        // Fetch below the base wraps to a huge index
        do_reset();
        instr_address = 32'h00000000;
        #1;
        chk("instr_wrap_data", instr_readdata, 32'd0);
        cycle();
        instr_address = INSTR_BASE;
        chk("instr_wrap_err", 32'(addr_error), 32'd1);

        // Out-of-range init write is dropped
        do_reset();
        init_mem      = 1'b1;
        init_mem_addr = 32'd256;
        init_instr    = 32'hDEADBEEF;
        cycle();
        init_mem = 1'b0;
        cycle();
        chk("init_oob_err", 32'(addr_error), 32'd1);
        chk("init_oob_no_write", instr_readdata, 32'h8C0C0000);

        // Simultaneous read and write
        do_reset();
        data_op(1'b1, 1'b0, 32'h8, 32'd3);
        cycle();
        data_op(1'b1, 1'b1, 32'h8, 32'd9);
        #1;
        chk("simul_old_data", data_readdata, 32'd3);
        cycle();
        data_op(1'b0, 1'b1, 32'h8, 32'd0);
        #1;
        chk("simul_new_data", data_readdata, 32'd9);
        chk("simul_err", 32'(addr_error), 32'd1);
        chk("simul_wc", 32'(write_count), 32'd2);
        idle();

        // Randomized traffic against the reference model
        do_reset();
        for (int n = 0; n < 300; n++) begin
            int          op;
            int          k;
            bit          wr;
            bit          rd;
            logic [31:0] a;
            logic [31:0] exp_rd;
            op = int'($urandom_range(0, 9));
            wr = (op >= 2 && op <= 5);
            rd = (op >= 6);
            a  = 32'($urandom_range(0, 15)) * 32'd4;
            if (wr && $urandom_range(0, 19) == 0) begin
                a = ($urandom_range(0, 1) == 0) ? 32'h400 + a : a + 32'd1;
            end
            k = int'($urandom_range(0, 3));
            instr_address = INSTR_BASE + 32'(4 * k);
            data_op(wr, rd, a, $urandom);
            exp_rd = (rd && dvalid(a)) ? dm[(a - DATA_BASE) / 4] : 32'd0;
            #1;
            chk("rand_rdata", data_readdata, exp_rd);
            chk("rand_instr", instr_readdata, prog[k]);
            if (wr && dvalid(a)) begin
                dm[(a - DATA_BASE) / 4] = data_writedata;
                if (m_wc < 65535) m_wc++;
            end
            if ((wr || rd) && !dvalid(a)) m_err = 1'b1;
            cycle();
            chk("rand_wc", 32'(write_count), 32'(m_wc));
            chk("rand_err", 32'(addr_error), 32'(m_err));
        end
        idle();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mips_harvard_mem_model.md
Name: mips_harvard_mem_model

Overview:
- Parametrised Harvard memory model that replaces hand-driven instr_readdata/data_readdata stimulus in CPU benches.
- Provides a separate instruction ROM and data RAM, and loads the ROM through an init stream.
- Generates clk_enable for the CPU, adds address-error checking and a write counter.
- Sits between the bench top and mips_cpu_harvard; connects one-to-one to the CPU's memory ports.

Parameters:
INSTR_DEPTH, 256, instruction memory size in 32-bit words (power of 2)
DATA_DEPTH, 256, data memory size in 32-bit words (power of 2)
INSTR_BASE, 32'hBFC00000, byte address of instruction word 0
DATA_BASE, 32'h00000000, byte address of data word 0
STALL_CYCLES, 2, clk_enable low cycles after each data access (only with MEM_STALL_EN; range 1-15)

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
init_mem  input  1  init stream valid; writes init_instr into instruction memory
init_mem_addr  input  32  word index (not byte address) for init write
init_instr  input  32  instruction word to load
clk_enable  output  1  CPU clock enable
instr_address  input  32  CPU instruction byte address
instr_readdata  output  32  combinational instruction read
data_address  input  32  CPU data byte address
data_write  input  1  data write strobe
data_read  input  1  data read strobe
data_writedata  input  32  data write value
data_readdata  output  32  combinational data read
addr_error  output  1  sticky error flag
write_count  output  16  accepted data writes, saturating

Behaviour:
- Reset (synchronous, active-high):
  - State goes to RUN; clk_enable=0 during the reset cycle.
  - addr_error=0; write_count=0.
  - Data RAM cleared to 0.
  - Instruction RAM is NOT cleared, so loaded programs survive reset.
- FSM states: LOAD, RUN, STALL.
  - Any state with init_mem=1 -> LOAD. init_mem has priority over everything except reset.
  - LOAD: clk_enable=0. Each cycle with init_mem=1 writes init_instr to instr_mem[init_mem_addr].
  - LOAD with init_mem=0 -> RUN on the next posedge, so clk_enable rises one cycle after init_mem falls.
  - RUN: clk_enable=1.
- Instruction read (combinational):
  - idx = (instr_address - INSTR_BASE) >> 2.
  - Valid when instr_address[1:0]==0 and idx < INSTR_DEPTH; instr_readdata = instr_mem[idx].
  - Otherwise instr_readdata=0, and addr_error sets at the next posedge if clk_enable=1.
- Data read (combinational):
  - didx = (data_address - DATA_BASE) >> 2.
  - data_readdata = data_mem[didx] when data_read=1 and the address is valid; else 0.
- Data write:
  - At posedge when data_write=1, clk_enable=1 and the address is valid: data_mem[didx] <= data_writedata.
  - write_count increments and saturates at 16'hFFFF.
  - Invalid or misaligned address: no write, no count, addr_error sets.
- data_read and data_write both high in the same cycle: write is performed, read data is the old value, addr_error sets.
- init_mem_addr >= INSTR_DEPTH: write dropped, addr_error sets.
- addr_error is sticky until reset.
- Accesses while clk_enable=0 are ignored for writes, counting and error checks; reads are still driven.
- Address arithmetic is unsigned 32-bit; a wrap below the base gives a large idx, which is treated as out of range.

Optional Feature:
- Macro: MEM_STALL_EN.
- Defined:
  - RUN cycle with an accepted data access (data_read or data_write, valid, clk_enable=1) -> STALL.
  - STALL holds clk_enable=0 for exactly STALL_CYCLES cycles using a 4-bit down-counter, then returns to RUN.
  - In STALL, reads stay combinationally driven; writes, counting and error checks are suppressed.
  - init_mem during STALL -> LOAD and the counter is cleared.
- Undefined: no STALL state; clk_enable=1 in every RUN cycle.

Test Plan:
- Load + run:
  - Stimulus: init words 0..3 = {8C0C0000, 8C090000, 01891821, AC030000}, then drop init_mem.
  - Required: clk_enable=0 during load, 1 one cycle after; instr_address=BFC00008 returns 01891821.
- Write/read:
  - Stimulus: data_write at address 0x10 with value 7, then data_read at 0x10.
  - Required: data_readdata=7; write_count=1; data_readdata=0 when data_read=0.
- Errors:
  - Stimulus: instr_address=BFC00002; separately data_write at 0x400 (DATA_DEPTH=256).
  - Required: instr_readdata=0; addr_error=1; no write; write_count unchanged; addr_error stays 1 until reset.
- Reset mid-program:
  - Stimulus: write 5 to 0x0, then pulse reset.
  - Required: data_mem[0]=0; write_count=0; addr_error=0; instruction word 0 still 8C0C0000.
- Simultaneous access:
  - Stimulus: data_read=1 and data_write=1 at 0x8 (old value 3, new value 9).
  - Required: data_readdata=3 that cycle, 9 afterwards; addr_error=1.
- MEM_STALL_EN, STALL_CYCLES=2:
  - Stimulus: a single data_read.
  - Required: clk_enable pattern 1,0,0,1; data_readdata stays valid throughout.
